// File: rtl/mul_pipe.sv
// Pipelined RV64M integer multiplier with valid/ready writeback backpressure and flush.
// Optional performance counters are enabled by defining MUL_PERF_CNT_EN.
module mul_pipe #(
  parameter int W      = 64,
  parameter int LAT    = 3,
  parameter int LG_ROB = 5,
  parameter int LG_PRF = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  output logic              in_ready,
  input  logic [2:0]        op,
  input  logic [W-1:0]      src_A,
  input  logic [W-1:0]      src_B,
  input  logic [LG_ROB-1:0] rob_ptr_in,
  input  logic              prf_val_in,
  input  logic [LG_PRF-1:0] prf_ptr_in,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [W-1:0]      y,
  output logic [LG_ROB-1:0] rob_ptr_out,
  output logic              prf_val_out,
  output logic [LG_PRF-1:0] prf_ptr_out,
  output logic [31:0]       op_cnt,
  output logic [31:0]       stall_cnt
);

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_MULW   = 3'd4
  } op_e;

  typedef struct packed {
    logic [W-1:0]      res;
    logic [LG_ROB-1:0] rob;
    logic              prf_val;
    logic [LG_PRF-1:0] prf;
  } stage_t;

  stage_t          st [LAT];
  logic [LAT-1:0]  vld;
  logic            adv;
  logic            accept;
  logic [2*W-1:0]  ea, eb, prod;
  logic [31:0]     mw;
  logic [W-1:0]    res;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = go && adv && !flush;

  // Operands are extended to 2W with per-op signedness so one multiplier serves all high-half ops.
  always_comb begin
    ea   = {{W{src_A[W-1]}}, src_A};
    eb   = {{W{src_B[W-1]}}, src_B};
    res  = '0;
    case (op)
      OP_MULHSU: eb = {{W{1'b0}}, src_B};
      OP_MULHU: begin
        ea = {{W{1'b0}}, src_A};
        eb = {{W{1'b0}}, src_B};
      end
      default: ;
    endcase
    prod = ea * eb;
    mw   = src_A[31:0] * src_B[31:0];
    case (op)
      OP_MUL:                       res = prod[W-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod[2*W-1:W];
      OP_MULW:                      res = W'($signed(mw));
      default:                      res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0;
      for (int unsigned i = 0; i < LAT; i++) st[i] <= '0;
    end else begin
      if (flush) begin
        vld <= '0;
      end else if (adv) begin
        vld[0] <= accept;
        for (int unsigned i = 1; i < LAT; i++) vld[i] <= vld[i-1];
      end
      // Payload shifts on advance even under flush; stale payload behind a cleared valid is harmless.
      if (adv) begin
        st[0] <= '{res: res, rob: rob_ptr_in, prf_val: prf_val_in, prf: prf_ptr_in};
        for (int unsigned i = 1; i < LAT; i++) st[i] <= st[i-1];
      end
    end
  end

  assign out_valid   = vld[LAT-1];
  assign y           = st[LAT-1].res;
  assign rob_ptr_out = st[LAT-1].rob;
  assign prf_val_out = st[LAT-1].prf_val;
  assign prf_ptr_out = st[LAT-1].prf;

`ifdef MUL_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_cnt    <= '0;
      stall_cnt <= '0;
    end else begin
      if (accept) op_cnt <= op_cnt + 32'd1;
      if (out_valid && !out_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
  assign op_cnt    = '0;
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// Self-checking bench for mul_pipe: directed scenarios plus a randomized stream
// checked against a queue-based arithmetic reference model.
module tb_mul_pipe;
  localparam int W = 64, LAT = 3, LG_ROB = 5, LG_PRF = 6;

  logic              clk = 1'b0;
  logic              reset, go, in_ready, prf_val_in, flush, out_valid, out_ready, prf_val_out;
  logic [2:0]        op;
  logic [W-1:0]      src_A, src_B, y;
  logic [LG_ROB-1:0] rob_ptr_in, rob_ptr_out;
  logic [LG_PRF-1:0] prf_ptr_in, prf_ptr_out;
  logic [31:0]       op_cnt, stall_cnt;

  int tests = 0;
  int fails = 0;

  mul_pipe #(.W(W), .LAT(LAT), .LG_ROB(LG_ROB), .LG_PRF(LG_PRF)) dut (
    .clk(clk), .reset(reset), .go(go), .in_ready(in_ready), .op(op),
    .src_A(src_A), .src_B(src_B), .rob_ptr_in(rob_ptr_in), .prf_val_in(prf_val_in),
    .prf_ptr_in(prf_ptr_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .rob_ptr_out(rob_ptr_out), .prf_val_out(prf_val_out), .prf_ptr_out(prf_ptr_out),
    .op_cnt(op_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]       y;
    logic [LG_ROB-1:0] rob;
    logic              pv;
    logic [LG_PRF-1:0] prf;
  } exp_t;

  // Reference: RV64M semantics computed with wide arithmetic.
  function automatic logic [63:0] ref_mul(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b);
    logic signed [127:0] p;
    int r;
    p = '0;
    case (o)
      3'd0: return a * b;
      3'd1: p = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b});
      3'd2: p = $signed({{64{a[63]}}, a}) * $signed({64'd0, b});
      3'd3: p = {64'd0, a} * {64'd0, b};
      3'd4: begin
        r = a[31:0] * b[31:0];
        return {{32{r[31]}}, r};
      end
      default: return 64'd0;
    endcase
    return p[127:64];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                       input int rob, input logic pv, input int prf);
    go = 1'b1; op = o; src_A = a; src_B = b;
    rob_ptr_in = rob[LG_ROB-1:0]; prf_val_in = pv; prf_ptr_in = prf[LG_PRF-1:0];
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; flush = 1'b0; out_ready = 1'b1;
    op = '0; src_A = '0; src_B = '0; rob_ptr_in = '0; prf_val_in = 1'b0; prf_ptr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tests++; if (y !== '0) begin fails++; $display("FAIL reset_y got=%h exp=0", y); end
    tests++; if ({rob_ptr_out, prf_val_out, prf_ptr_out} !== '0) begin fails++; $display("FAIL reset_tags got=%h exp=0", {rob_ptr_out, prf_val_out, prf_ptr_out}); end
    tests++; if ({op_cnt, stall_cnt} !== 64'd0) begin fails++; $display("FAIL reset_cnt got=%h exp=0", {op_cnt, stall_cnt}); end
    reset = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    tick();
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    drive(3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 7, 1'b1, 12);
    tick(); go = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early cyc=%0d got=%b exp=0", k, out_valid); end
      tick();
    end
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    tests++; if (y !== 64'hFFFF_FFFF_FFFF_FFF1) begin fails++; $display("FAIL basic_y got=%h exp=fffffffffffffff1", y); end
    tests++; if (rob_ptr_out !== 5'd7 || prf_ptr_out !== 6'd12 || prf_val_out !== 1'b1) begin
      fails++; $display("FAIL basic_tags got rob=%0d prf=%0d pv=%b exp rob=7 prf=12 pv=1", rob_ptr_out, prf_ptr_out, prf_val_out);
    end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_one_cycle got=%b exp=0", out_valid); end
  endtask

  task automatic test_ops();
    logic [2:0]  vo [5] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd6};
    logic [63:0] va [5] = '{'1, '1, '1, 64'h8000_0000, 64'h1234};
    logic [63:0] vb [5] = '{'1, '1, 64'd2, 64'd1, 64'h5678};
    logic [63:0] ve [5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                            64'hFFFF_FFFF_8000_0000, 64'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(vo[i], va[i], vb[i], i + 1, i[0], i + 20);
      tick(); go = 1'b0;
      repeat (LAT - 1) tick();
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ops_valid op=%0d got=%b exp=1", vo[i], out_valid); end
      tests++; if (y !== ve[i]) begin fails++; $display("FAIL ops_y op=%0d got=%h exp=%h", vo[i], y, ve[i]); end
      tests++; if (rob_ptr_out !== LG_ROB'(i + 1) || prf_val_out !== i[0]) begin
        fails++; $display("FAIL ops_tags op=%0d got rob=%0d pv=%b exp rob=%0d pv=%b", vo[i], rob_ptr_out, prf_val_out, i + 1, i[0]);
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] got[$];
    int issued = 0, stall_left = 2;
    logic [31:0] s0 = stall_cnt;
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      out_ready = 1'b1;
      if (out_valid && stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      if (issued < 4) drive(3'd0, 64'(issued + 1), 64'd10, issued, 1'b1, issued);
      else go = 1'b0;
      #1;
      if (!out_ready) begin
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
      end
      if (go && in_ready) issued++;
      if (out_valid && out_ready) got.push_back(y);
      tick();
    end
    go = 1'b0;
    tests++; if (got.size() != 4) begin fails++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      tests++; if (got[i] !== 64'(10 * (i + 1))) begin fails++; $display("FAIL bp_order idx=%0d got=%0d exp=%0d", i, got[i], 10 * (i + 1)); end
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_dup got=%b exp=0", out_valid); end
`ifdef MUL_PERF_CNT_EN
    tests++; if (stall_cnt - s0 !== 32'd2) begin fails++; $display("FAIL bp_stall_cnt got=%0d exp=2", stall_cnt - s0); end
`else
    tests++; if (stall_cnt !== 32'd0 || s0 !== 32'd0) begin fails++; $display("FAIL bp_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    drive(3'd0, 64'd2, 64'd3, 1, 1'b1, 1); tick();
    drive(3'd0, 64'd4, 64'd5, 2, 1'b1, 2); tick();
    flush = 1'b1;
    drive(3'd0, 64'd8, 64'd9, 3, 1'b1, 3); tick();
    flush = 1'b0; go = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_quiet cyc=%0d got=%b exp=0", k, out_valid); end
      tick();
    end
    drive(3'd0, 64'd6, 64'd7, 9, 1'b1, 9); tick(); go = 1'b0;
    repeat (LAT - 1) tick();
    tests++; if (out_valid !== 1'b1 || y !== 64'd42 || rob_ptr_out !== 5'd9) begin
      fails++; $display("FAIL flush_after got v=%b y=%0d rob=%0d exp v=1 y=42 rob=9", out_valid, y, rob_ptr_out);
    end
    tick();
  endtask

  task automatic test_flush_stall();
    out_ready = 1'b0;
    drive(3'd0, 64'd5, 64'd5, 4, 1'b1, 4); tick(); go = 1'b0;
    repeat (LAT - 1) tick();
    tick();
    tests++; if (out_valid !== 1'b1 || y !== 64'd25) begin fails++; $display("FAIL fs_hold got v=%b y=%0d exp v=1 y=25", out_valid, y); end
    flush = 1'b1; out_ready = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fs_valid got=%b exp=0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL fs_in_ready got=%b exp=1", in_ready); end
    repeat (4) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL fs_quiet got=%b exp=0", out_valid); end
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin drive(3'd0, 64'(7 + i), 64'd9, 5 + i, 1'b1, 11 + i); tick(); end
    go = 1'b0;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL ar_pre got=%b exp=1", out_valid); end
    #2 reset = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || y !== '0) begin fails++; $display("FAIL ar_async got v=%b y=%h exp v=0 y=0", out_valid, y); end
    tests++; if ({rob_ptr_out, prf_val_out, prf_ptr_out} !== '0) begin fails++; $display("FAIL ar_tags got=%h exp=0", {rob_ptr_out, prf_val_out, prf_ptr_out}); end
    #2 reset = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL ar_stale cyc=%0d got=%b exp=0", k, out_valid); end
    end
    tests++; if (op_cnt !== 32'd0) begin fails++; $display("FAIL ar_op_cnt got=%0d exp=0", op_cnt); end
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {32'd0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic test_random();
    localparam int N = 80;
    exp_t q[$];
    exp_t e;
    int n_acc = 0, n_done = 0;
    bit have = 0, prev_stall = 0;
    logic [63:0] prev_y = '0;
    logic [LG_ROB-1:0] prev_rob = '0;
    logic [31:0] c0 = op_cnt;
    for (int cyc = 0; cyc < 3000 && n_done < N; cyc++) begin
      out_ready = ($urandom_range(0, 9) < 7);
      if (!have && n_acc < N && $urandom_range(0, 3) != 0) begin
        drive(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), $urandom_range(0, 31),
              1'($urandom_range(0, 1)), $urandom_range(0, 63));
        have = 1;
      end else if (!have) go = 1'b0;
      #1;
      if (prev_stall) begin
        tests++; if (out_valid !== 1'b1 || y !== prev_y || rob_ptr_out !== prev_rob) begin
          fails++; $display("FAIL rnd_hold got v=%b y=%h rob=%0d exp v=1 y=%h rob=%0d", out_valid, y, rob_ptr_out, prev_y, prev_rob);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (q.size() == 0) begin fails++; $display("FAIL rnd_extra got y=%h exp no result", y); end
        else begin
          e = q.pop_front();
          if (y !== e.y || rob_ptr_out !== e.rob || prf_val_out !== e.pv || prf_ptr_out !== e.prf) begin
            fails++; $display("FAIL rnd_result got y=%h rob=%0d pv=%b prf=%0d exp y=%h rob=%0d pv=%b prf=%0d",
                              y, rob_ptr_out, prf_val_out, prf_ptr_out, e.y, e.rob, e.pv, e.prf);
          end
        end
        n_done++;
      end
      if (go && in_ready) begin
        q.push_back('{y: ref_mul(op, src_A, src_B), rob: rob_ptr_in, pv: prf_val_in, prf: prf_ptr_in});
        n_acc++; have = 0;
      end
      prev_stall = out_valid && !out_ready; prev_y = y; prev_rob = rob_ptr_out;
      @(posedge clk); #1;
      if (!have) go = 1'b0;
    end
    go = 1'b0; out_ready = 1'b1;
    tests++; if (n_done != N) begin fails++; $display("FAIL rnd_timeout got=%0d exp=%0d", n_done, N); end
`ifdef MUL_PERF_CNT_EN
    tests++; if (op_cnt - c0 !== 32'(N)) begin fails++; $display("FAIL rnd_op_cnt got=%0d exp=%0d", op_cnt - c0, N); end
`else
    tests++; if (op_cnt !== 32'd0 || c0 !== 32'd0) begin fails++; $display("FAIL rnd_op_cnt got=%0d exp=0", op_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ops();
    test_backpressure();
    test_flush();
    test_flush_stall();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
